// File: rtl/display_scan_dbuf_if.sv
// Frame-generator side of the scan driver: back-buffer row writes plus the swap request/acknowledge pair.
interface display_scan_dbuf_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic                    wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [COLS-1:0]         wr_data;
  logic                    swap_req;
  logic                    swap_ack;

  modport master (output wr_en, wr_row, wr_data, swap_req, input swap_ack);
  modport slave  (input wr_en, wr_row, wr_data, swap_req, output swap_ack);
endinterface

// File: rtl/display_scan_dbuf.sv
// Row-scanning LED matrix driver with a double-buffered frame store, per-row blanking,
// row-aligned PWM and configurable pin polarity. All outputs are registered.
module display_scan_dbuf #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int PWM_WIDTH    = 8,
  parameter int SCAN_MAX     = 25000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ROW_ACTIVE_HIGH = 1'b1,
  parameter bit COL_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  display_scan_dbuf_if.slave      fb,
  input  logic [PWM_WIDTH-1:0]    brightness,
  output logic [ROWS-1:0]         row,
  output logic [COLS-1:0]         col,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_start
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(SCAN_MAX);
  localparam logic [ROWS-1:0] ROW_IDLE = ROW_ACTIVE_HIGH ? '0 : '1;
  localparam logic [COLS-1:0] COL_IDLE = COL_ACTIVE_LOW  ? '1 : '0;

  logic [CNT_W-1:0]     scan_cnt;
  logic [ROW_W-1:0]     row_cnt;
  logic [PWM_WIDTH-1:0] bri_s;
  logic                 front_sel;
  logic                 pending;
  logic                 swapped;
  logic [COLS-1:0]      frame_buf [2][ROWS];

  logic                 last_cycle;
  logic                 frame_end;
  logic                 row_start0;
  logic                 active;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] bri_now;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_lit;

  // Decode of the current counter state; the registers below present it one clock later.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch can be inferred.
    row_sel    = '0;
    col_lit    = '0;
    last_cycle = (scan_cnt == CNT_W'(SCAN_MAX - 1));
    frame_end  = last_cycle && (row_cnt == ROW_W'(ROWS - 1));
    row_start0 = (scan_cnt == '0) && (row_cnt == '0);
    active     = (scan_cnt >= CNT_W'(BLANK_CYCLES));
    pwm_cnt    = PWM_WIDTH'(scan_cnt - CNT_W'(BLANK_CYCLES));
    bri_now    = (scan_cnt == '0) ? brightness : bri_s;
    for (int r = 0; r < ROWS; r++) begin
      row_sel[r] = active && (row_cnt == ROW_W'(r));
    end
    if (active && (pwm_cnt < bri_now)) begin
      col_lit = frame_buf[front_sel][row_cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      row_cnt     <= '0;
      bri_s       <= '0;
      front_sel   <= 1'b0;
      pending     <= 1'b0;
      swapped     <= 1'b0;
      // NOTE: the frame store is plain flip-flops and is cleared on reset so a reset always blanks the display.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          frame_buf[b][r] <= '0;
        end
      end
      row         <= ROW_IDLE;
      col         <= COL_IDLE;
      row_idx     <= '0;
      frame_start <= 1'b0;
      fb.swap_ack <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state.
      if (scan_cnt == '0) begin
        bri_s <= brightness;
      end

      row         <= ROW_ACTIVE_HIGH ? row_sel : ~row_sel;
      col         <= COL_ACTIVE_LOW ? ~col_lit : col_lit;
      row_idx     <= row_cnt;
      frame_start <= row_start0;
      fb.swap_ack <= row_start0 && swapped;

      // Writes land in the back buffer as selected before any swap on this edge.
      if (fb.wr_en && (int'(fb.wr_row) < ROWS)) begin
        frame_buf[~front_sel][fb.wr_row] <= fb.wr_data;
      end

      if (last_cycle) begin
        scan_cnt <= '0;
        row_cnt  <= frame_end ? '0 : row_cnt + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (row_start0) begin
        swapped <= 1'b0;
      end
      if (frame_end && pending) begin
        front_sel <= ~front_sel;
        pending   <= fb.swap_req;
        swapped   <= 1'b1;
      end else begin
        pending   <= pending | fb.swap_req;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_dbuf.sv
// Randomised bench for display_scan_dbuf: two instances (normal and inverted polarity) checked against a frame-level model.
module tb_display_scan_dbuf;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int PW    = 4;
  localparam int SM    = 40;
  localparam int BL    = 4;
  localparam int FRAME = ROWS * SM;
  localparam int RW    = $clog2(ROWS);
  localparam int OW    = ROWS + COLS + RW + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PW-1:0]   brightness = '0;
  logic            wr_en = 1'b0;
  logic [RW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            swap_req = 1'b0;

  logic [ROWS-1:0] a_row, b_row;
  logic [COLS-1:0] a_col, b_col;
  logic [RW-1:0]   a_idx, b_idx;
  logic            a_fs, b_fs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_scan_dbuf_if #(.ROWS(ROWS), .COLS(COLS)) a_if ();
  display_scan_dbuf_if #(.ROWS(ROWS), .COLS(COLS)) b_if ();

  assign a_if.wr_en = wr_en;  assign a_if.wr_row = wr_row;  assign a_if.wr_data = wr_data;  assign a_if.swap_req = swap_req;
  assign b_if.wr_en = wr_en;  assign b_if.wr_row = wr_row;  assign b_if.wr_data = wr_data;  assign b_if.swap_req = swap_req;

  display_scan_dbuf #(.ROWS(ROWS), .COLS(COLS), .PWM_WIDTH(PW), .SCAN_MAX(SM), .BLANK_CYCLES(BL),
                      .ROW_ACTIVE_HIGH(1'b1), .COL_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fb(a_if.slave), .brightness(brightness),
    .row(a_row), .col(a_col), .row_idx(a_idx), .frame_start(a_fs));

  display_scan_dbuf #(.ROWS(ROWS), .COLS(COLS), .PWM_WIDTH(PW), .SCAN_MAX(SM), .BLANK_CYCLES(BL),
                      .ROW_ACTIVE_HIGH(1'b0), .COL_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fb(b_if.slave), .brightness(brightness),
    .row(b_row), .col(b_col), .row_idx(b_idx), .frame_start(b_fs));

  wire [OW-1:0] a_obs = {a_row, a_col, a_idx, a_fs, a_if.swap_ack};
  wire [OW-1:0] b_obs = {b_row, b_col, b_idx, b_fs, b_if.swap_ack};

  // Reference model: frame position, two pixel arrays exchanged wholesale on a swap.
  logic [COLS-1:0] m_front [ROWS];
  logic [COLS-1:0] m_back  [ROWS];
  logic [COLS-1:0] m_tmp   [ROWS];
  int              m_pos, m_bri, m_r, m_sc;
  bit              m_pend, m_fresh;
  logic [ROWS-1:0] e_row;
  logic [COLS-1:0] e_col;
  logic [OW-1:0]   a_exp, b_exp;

  initial begin
    a_exp = '0;
    b_exp = '0;
    forever begin
      @(posedge clk);
      e_row = '0;
      e_col = '1;
      if (rst) begin
        m_pos = 0; m_bri = 0; m_pend = 0; m_fresh = 0;
        for (int r = 0; r < ROWS; r++) begin m_front[r] = '0; m_back[r] = '0; end
        a_exp = {e_row, e_col, RW'(0), 1'b0, 1'b0};
        b_exp = {~e_row, ~e_col, RW'(0), 1'b0, 1'b0};
      end else begin
        m_r  = m_pos / SM;
        m_sc = m_pos % SM;
        if (m_sc == 0) m_bri = int'(brightness);
        if (m_sc >= BL) begin
          e_row = ROWS'(1) << m_r;
          if (((m_sc - BL) % (1 << PW)) < m_bri) e_col = ~m_front[m_r];
        end
        a_exp = {e_row, e_col, RW'(m_r), m_pos == 0, (m_pos == 0) && m_fresh};
        b_exp = {~e_row, ~e_col, RW'(m_r), m_pos == 0, (m_pos == 0) && m_fresh};
        if (m_pos == 0) m_fresh = 0;
        if (wr_en && int'(wr_row) < ROWS) m_back[wr_row] = wr_data;
        if (m_pos == FRAME - 1 && m_pend) begin
          m_tmp = m_front; m_front = m_back; m_back = m_tmp;
          m_pend = swap_req; m_fresh = 1;
        end else begin
          m_pend = m_pend | swap_req;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
    end
  end

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (a_fs) ok = 1;
    end
  endtask

  task automatic test_reset();
    int fs_cnt = 0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({a_row, a_col, a_fs, a_if.swap_ack} !== {4'b0000, 4'b1111, 2'b00}) begin
        n_fail++; $display("FAIL reset_a got %b want %b", {a_row, a_col, a_fs, a_if.swap_ack}, {4'b0000, 4'b1111, 2'b00});
      end
      n_tests++;
      if ({b_row, b_col, b_fs, b_if.swap_ack} !== {4'b1111, 4'b0000, 2'b00}) begin
        n_fail++; $display("FAIL reset_b got %b want %b", {b_row, b_col, b_fs, b_if.swap_ack}, {4'b1111, 4'b0000, 2'b00});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 330; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL idle_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL idle_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_fs) begin
        fs_cnt++;
        n_tests++;
        if (k % FRAME != 0) begin n_fail++; $display("FAIL idle_fs_pos got k=%0d want multiple of %0d", k, FRAME); end
      end
    end
    n_tests++;
    if (fs_cnt != 3) begin n_fail++; $display("FAIL idle_fs_count got %0d want 3", fs_cnt); end
  endtask

  task automatic test_swap_full();
    bit got = 0;
    int dark_bad = 0, lit = 0;
    brightness = 4'd8;
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1'b1; wr_row = RW'(r); wr_data = 4'hF;
      @(negedge clk);
    end
    wr_en = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL swap_wait_a i=%0d got %b want %b", i, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL swap_wait_b i=%0d got %b want %b", i, b_obs, b_exp); end
      if (a_if.swap_ack) got = 1;
      else if (a_col !== 4'hF) dark_bad++;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL swap_ack_timeout got none want pulse"); end
    n_tests++;
    if (a_fs !== 1'b1) begin n_fail++; $display("FAIL swap_ack_with_fs got fs=%b want 1", a_fs); end
    n_tests++;
    if (dark_bad != 0) begin n_fail++; $display("FAIL pre_swap_dark got %0d lit cycles want 0", dark_bad); end
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL swap_frame_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL swap_frame_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_col == 4'h0) lit++;
    end
    n_tests++;
    if (lit != 80) begin n_fail++; $display("FAIL swap_frame_duty got %0d want 80", lit); end
  endtask

  task automatic test_brightness_extremes();
    bit ok;
    int lit;
    for (int pass = 0; pass < 2; pass++) begin
      brightness = (pass == 0) ? 4'd0 : 4'd15;
      wait_fs(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL bri_fs_timeout got none want frame_start"); end
      lit = 0;
      for (int k = 1; k < FRAME; k++) begin
        @(negedge clk);
        n_tests++;
        if (a_obs !== a_exp) begin n_fail++; $display("FAIL bri_a k=%0d got %b want %b", k, a_obs, a_exp); end
        n_tests++;
        if (b_obs !== b_exp) begin n_fail++; $display("FAIL bri_b k=%0d got %b want %b", k, b_obs, b_exp); end
        if (pass == 0 && a_col != 4'hF) lit++;
        if (pass == 1 && a_col == 4'h0) lit++;
      end
      n_tests++;
      if (lit != ((pass == 0) ? 0 : 136)) begin
        n_fail++; $display("FAIL bri_duty pass=%0d got %0d want %0d", pass, lit, (pass == 0) ? 0 : 136);
      end
    end
  endtask

  task automatic test_mid_row_brightness();
    bit ok;
    int lit_row [ROWS];
    int want    [ROWS];
    want = '{20, 20, 34, 34};
    for (int r = 0; r < ROWS; r++) lit_row[r] = 0;
    brightness = 4'd8;
    wait_fs(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL midbri_fs_timeout got none want frame_start"); end
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL midbri_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL midbri_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_col == 4'h0) lit_row[k / SM]++;
      if (k == SM + 19) brightness = 4'd15;
    end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++;
      if (lit_row[r] != want[r]) begin n_fail++; $display("FAIL midbri_row%0d got %0d want %0d", r, lit_row[r], want[r]); end
    end
  endtask

  task automatic test_swap_merge();
    bit ok;
    int acks = 0, ack_k = -1;
    int s1 = int'($urandom_range(5, 50));
    int s2 = int'($urandom_range(51, 100));
    int s3 = int'($urandom_range(101, 150));
    wait_fs(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL merge_fs_timeout got none want frame_start"); end
    for (int k = 1; k <= 2 * FRAME + 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL merge_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL merge_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_if.swap_ack) begin acks++; ack_k = k; end
      swap_req = (k == s1 || k == s2 || k == s3);
    end
    n_tests++;
    if (acks != 1 || ack_k != FRAME) begin n_fail++; $display("FAIL merge_acks got %0d at k=%0d want 1 at k=%0d", acks, ack_k, FRAME); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acks = 0, first_k = -1, last_k = -1;
    wait_fs(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_fs_timeout got none want frame_start"); end
    for (int k = 1; k <= 2 * FRAME + 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL b2b_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL b2b_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_if.swap_ack) begin acks++; if (first_k < 0) first_k = k; last_k = k; end
      swap_req = (k == 10 || k == FRAME - 2);
      wr_en    = (k == FRAME - 2);
      wr_row   = '0;
      wr_data  = COLS'($urandom);
    end
    wr_en = 1'b0;
    n_tests++;
    if (acks != 2 || first_k != FRAME || last_k != 2 * FRAME) begin
      n_fail++; $display("FAIL b2b_acks got %0d at %0d/%0d want 2 at %0d/%0d", acks, first_k, last_k, FRAME, 2 * FRAME);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL rand_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL rand_b k=%0d got %b want %b", k, b_obs, b_exp); end
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = RW'($urandom);
      wr_data  = COLS'($urandom);
      swap_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) brightness = PW'($urandom);
    end
    wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit got = 0;
    int acks = 0, lit = 0;
    brightness = 4'd15;
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1'b1; wr_row = RW'(r); wr_data = 4'hF;
      @(negedge clk);
    end
    wr_en = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      @(negedge clk);
      if (a_if.swap_ack) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL rst_prep_timeout got none want swap_ack"); end
    for (int k = 1; k <= 2 * SM + 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL rst_pre_a k=%0d got %b want %b", k, a_obs, a_exp); end
      swap_req = (k == 50);
    end
    rst = 1'b1; swap_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_obs !== {4'b0000, 4'b1111, RW'(0), 2'b00}) begin
      n_fail++; $display("FAIL rst_mid_a got %b want %b", a_obs, {4'b0000, 4'b1111, RW'(0), 2'b00});
    end
    n_tests++;
    if (b_obs !== {4'b1111, 4'b0000, RW'(0), 2'b00}) begin
      n_fail++; $display("FAIL rst_mid_b got %b want %b", b_obs, {4'b1111, 4'b0000, RW'(0), 2'b00});
    end
    rst = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_obs !== a_exp) begin n_fail++; $display("FAIL rst_post_a k=%0d got %b want %b", k, a_obs, a_exp); end
      n_tests++;
      if (b_obs !== b_exp) begin n_fail++; $display("FAIL rst_post_b k=%0d got %b want %b", k, b_obs, b_exp); end
      if (a_if.swap_ack) acks++;
      if (a_col != 4'hF) lit++;
      if (k == 200) begin
        n_tests++;
        if (acks != 0) begin n_fail++; $display("FAIL rst_pending_cleared got %0d acks want 0", acks); end
      end
      swap_req = (k == 201);
    end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL rst_swap_after got %0d acks want 1", acks); end
    n_tests++;
    if (lit != 0) begin n_fail++; $display("FAIL rst_dark got %0d lit cycles want 0", lit); end
  endtask

  initial begin
    test_reset();
    test_swap_full();
    test_brightness_extremes();
    test_mid_row_brightness();
    test_swap_merge();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/display_scan_dbuf.md
Name: display_scan_dbuf

Overview:
Parameterised successor to the single-frame 8x8 scan driver. It drives a ROWS x COLS LED matrix from an internal double-buffered frame store and adds per-row anti-ghost blanking. PWM is row-aligned, and output polarity is configurable. It sits between the animation/frame generator, which writes the back buffer and requests swaps, and the matrix pins.

Parameters:
ROWS, 8, number of matrix rows (2..32)
COLS, 8, number of matrix columns (1..32)
PWM_WIDTH, 8, brightness/PWM counter width
SCAN_MAX, 25000, clocks per row period; must exceed BLANK_CYCLES
BLANK_CYCLES, 16, clocks at the start of each row period with all rows/cols inactive
ROW_ACTIVE_HIGH, 1, 1: selected row driven 1; 0: selected row driven 0
COL_ACTIVE_LOW, 1, 1: lit column driven 0; 0: lit column driven 1

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
wr_en  in  1  write wr_data into back-buffer row wr_row
wr_row  in  $clog2(ROWS)  back-buffer row address; values >= ROWS ignored
wr_data  in  COLS  pixel bits for that row, 1 = pixel on
swap_req  in  1  request front/back exchange at next frame boundary
swap_ack  out  1  one-cycle pulse: swap performed
brightness  in  PWM_WIDTH  global duty, lit while pwm_cnt < sampled value
row  out  ROWS  row select, one-hot in the active phase
col  out  COLS  column drive
row_idx  out  $clog2(ROWS)  row currently scanned
frame_start  out  1  one-cycle pulse at start of row 0

Behaviour:
- Reset (rst=1 at posedge): scan_cnt=0, row_idx=0, both buffers cleared to 0, front-select=0, swap pending cleared.
- Output reset values: row = all inactive, col = all inactive, swap_ack=0, frame_start=0.
- Counters: scan_cnt runs 0..SCAN_MAX-1.
  - At SCAN_MAX-1: scan_cnt goes to 0 and row_idx increments; it wraps ROWS-1 -> 0, which is the frame boundary.
- Phases per row period:
  - BLANK: scan_cnt < BLANK_CYCLES; row and col are all inactive.
  - ACTIVE: otherwise.
- PWM in ACTIVE: pwm_cnt = (scan_cnt - BLANK_CYCLES) truncated to PWM_WIDTH; it wraps freely and restarts at 0 every row.
- Brightness sampling: bri_s samples brightness when scan_cnt==0 and is held for the whole row.
  - bri_s == 0: fully dark.
  - bri_s == 2^PWM_WIDTH-1: lit (2^W-1)/2^W of each PWM period.
- Pixel drive: a pixel is lit when ACTIVE, pwm_cnt < bri_s and front[row_idx][c]==1.
  - Apply COL_ACTIVE_LOW to col.
  - The selected row bit follows ROW_ACTIVE_HIGH; other rows are inactive.
- Latency: all outputs are registered, one clock after the counter state they decode.
  - Outputs at edge t+1 reflect (scan_cnt, row_idx, bri_s) at t.
  - row_idx output is that registered copy.
- Writes: wr_en writes back buffer only; the front buffer is never modified by wr_en.
- Swaps:
  - swap_req sets pending; repeated requests while pending merge into one swap.
  - On the cycle where the frame boundary is crossed with pending set: toggle front-select and clear pending.
  - swap_ack pulses coincident with frame_start of the first frame shown from the new buffer.
  - A swap_req arriving in that same cycle sets pending again for the next boundary.
  - The new back buffer holds the old front contents; no copy or clear is performed.
- wr_en in the swap cycle writes the pre-swap back buffer, so the data is visible in the frame just starting.
- frame_start pulses one cycle whenever row 0 begins (outputs of scan_cnt==0, row_idx==0), with or without a swap.
- brightness changes mid-row take effect only at the next row start, which guarantees glitch-free duty.
- rst asserted mid-frame: everything returns to reset values next edge, including buffer contents and pending swap; scanning restarts at row 0 BLANK.

Test Plan:
Test configuration: ROWS=4, COLS=4, PWM_WIDTH=4, SCAN_MAX=40, BLANK_CYCLES=4.
- Reset then idle: row=4'b0000, col=4'b1111 through reset.
  - frame_start pulses every 160 clocks; row_idx steps 0,1,2,3 every 40 clocks.
- Write all back rows 4'hF, swap_req=1 one cycle, brightness=8:
  - Frames before the boundary are dark.
  - swap_ack==frame_start at the boundary.
  - Each row is blank for 4 clocks, then col=0000 for 8 clocks and 1111 for 8 clocks, repeating.
  - row one-hot 0001,0010,0100,1000.
- Brightness 0: col stays 1111 all frame. Brightness 15: 15 of every 16 active clocks lit.
- Change brightness at scan_cnt=20 of row 1: duty changes only from row 2 onward.
- Three swap_req pulses within one frame: exactly one swap_ack. swap_req at the boundary cycle: a second swap one frame later.
- Flip ROW_ACTIVE_HIGH=0, COL_ACTIVE_LOW=0: all waveforms bit-inverted. Assert rst mid-row 2: outputs at reset values next edge and display dark (buffers cleared).
